// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 16x-oversampled mid-bit sampler and a valid/ack holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the par_err output.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk_12m,
  input  logic                 rst,
  input  logic                 rxclk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 par_err,
`endif
  output logic                 overrun
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 done_q, done_d;
  logic                 frame_err_q, frame_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 par_err_q, par_err_d;
`endif

  always_ff @(posedge clk_12m) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Frame sequencer: advances only on oversampling ticks; pulses are one clk wide.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif
    if (rxclk_en) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == MID) begin
            if (!rx_s_q) begin
              state_d = S_DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            par_bad_d = rx_s_q ^ (^shreg_q);
            state_d   = S_STOP;
          end
        end
`endif
        S_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d     = S_IDLE;
            frame_err_d = !rx_s_q;
`ifdef UART_RX_PARITY_EN
            par_err_d   = par_bad_q;
            done_d      = rx_s_q && !par_bad_q;
`else
            done_d      = rx_s_q;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Holding register: an ack in the completion cycle frees the slot for the new byte.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (data_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (done_q) begin
      if (!valid_q || data_ack) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign par_err    = par_err_q;
`endif

endmodule
